fprint_oflow_tracker: RTL and testbench
=======================================

Name: fprint_oflow_tracker

Overview:
- Responder for the comparator's overflow-register requests: count decrement (comparator_count_dec / oflow_count_dec_ack) and task reset (oflow_reset_task / oflow_reset_task_ack).
- Keeps one counter per (logical core, task) of fingerprints stored but not yet compared.
- Drives oflow_fprints_ready, oflow_fprints_remaining and oflow_fprints_remaining_logical_core_id back to the comparator.
- Counters are incremented by fingerprint-unit store strobes.

Parameters:
- KEY_SIZE, 16, number of task slots (one bit per task in ready/remaining vectors)
- KEY_WIDTH, 4, task id width, log2(KEY_SIZE)
- CNT_WIDTH, 5, per-counter width; maximum count 2^CNT_WIDTH-1

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- comparator_nmr  in  1  1 = triple-core mode (cores 0,1,2); 0 = dual-core mode (cores 0,1)
- fprint_store  in  1  one-cycle strobe: a fingerprint was stored
- fprint_store_core_id  in  2  logical core of stored fingerprint (0..2; 3 ignored)
- fprint_store_task_id  in  KEY_WIDTH  task of stored fingerprint
- comparator_task_id  in  KEY_WIDTH  task the comparator is working on
- comparator_count_dec  in  1  level request: decrement all active-core counters of comparator_task_id
- oflow_count_dec_ack  out  1  one-cycle ack for count_dec
- oflow_reset_task  in  1  level request: clear all counters of comparator_task_id
- oflow_reset_task_ack  out  1  one-cycle ack for reset_task
- oflow_fprints_ready  out  KEY_SIZE  per task: every active core count > 0
- oflow_fprints_remaining  out  KEY_SIZE  per task: any active core count > 0
- oflow_fprints_remaining_logical_core_id  out  2  for comparator_task_id: lowest core with count > 0, else 3
- oflow_error  out  1  sticky: a store hit a saturated counter or a decrement hit a zero counter

Behaviour:
- Reset: all counters 0, both acks 0, oflow_error 0, FSM in st_idle. ready and remaining are therefore all-zero and core_id is 3.
- Active cores: 0 and 1 always; core 2 only when comparator_nmr=1. Core-2 counters still count stores when nmr=0 but are excluded from ready, remaining, core_id and decrement.
- ready[t] = (c0>0) & (c1>0) & ((c2>0) | ~nmr).
- remaining[t] = OR over active cores of (c>0).
- Both vectors and core_id are combinational from registered counters, so each reflects an update one cycle after it.
- FSM states:
  - st_idle: if comparator_count_dec, go to st_dec_ack; else if oflow_reset_task, go to st_rst_ack. count_dec has priority.
  - st_dec_ack: oflow_count_dec_ack=1 for exactly one cycle; go to st_idle.
  - st_rst_ack: oflow_reset_task_ack=1 for exactly one cycle; go to st_idle.
- Counter action timing:
  - Decrement occurs on the idle→st_dec_ack edge, once per handshake. A level request still high during the ack cycle is not re-serviced.
  - Clear occurs on the idle→st_rst_ack edge.
  - Ack latency: ack is high in the cycle after the first request cycle. The comparator drops the request on the edge where it samples ack.
  - Back-to-back requests are served with at least one idle cycle between acks.
- Decrement: each active-core counter of the task decrements. A counter already at 0 stays 0 and sets oflow_error.
- Store:
  - Increments counter[core][task].
  - At max value the counter holds and oflow_error is set.
  - core_id=3 is ignored.
- Simultaneous events on the same counter:
  - Store + decrement: counter unchanged, no error, even if the counter was 0 or at max.
  - Store + clear: clear wins, the store is dropped.
  - Events on different counters proceed independently.
- comparator_task_id is sampled at the edge where the action occurs.
- Asynchronous reset mid-handshake: FSM returns to st_idle and acks drop immediately. A request still held afterwards is serviced normally.
- oflow_error clears only on reset, or as described under Optional Feature.

Optional Feature:
- FPRINT_OFLOW_ERR_ID_EN defined: adds output oflow_error_task_id (KEY_WIDTH) and input oflow_error_clear (1).
  - oflow_error_task_id captures the task of the first error since clear.
  - oflow_error_clear for one cycle clears oflow_error and the captured id. An error in the same cycle as the clear wins and is captured.
- FPRINT_OFLOW_ERR_ID_EN undefined: neither port exists, and oflow_error is reset-only.

Decomposition:
- Shared package/defines file: KEY_SIZE, KEY_WIDTH, CNT_WIDTH defaults, core-id constants (0, 1, 2, NONE=3).
- Sub-module fprint_oflow_task_cnt: one instance per task.
  - Inputs: store per core, dec, clr, nmr.
  - Outputs: three counters, ready bit, remaining bit, error pulse.
- Top level holds the handshake FSM, core_id priority encode and error sticky.

Test Plan:
- nmr=1; store task 5 on cores 0, 1, 2 → ready[5]=1 one cycle after the third store; remaining[5]=1; core_id=0 with comparator_task_id=5.
- nmr=1, counts 2/2/2 on task 5; hold count_dec 3 cycles until ack → ack high exactly 1 cycle, counts 1/1/1, single decrement only.
- nmr=0; store task 3 on core 1 only → ready[3]=0, remaining[3]=1, core_id=1.
- Store task 3 on core 0 in the same cycle as the core-0 decrement of task 3 → count unchanged, oflow_error=0.
- 31 stores then a 32nd on core 2 task 0 (CNT_WIDTH=5) → count holds 31, oflow_error=1; with FPRINT_OFLOW_ERR_ID_EN, error_task_id=0.
- Counts 4/0/7 on task 9; oflow_reset_task plus a store to task 9 in the same cycle → all counts 0, ack 1 cycle later, remaining[9]=0, core_id=3.

Source files
------------

// File: rtl/fprint_oflow_tracker_pkg.sv
// Shared definitions for the fingerprint overflow tracker.
// Holds the parameter defaults, the logical core ids and the handshake FSM encodings.
package fprint_oflow_tracker_pkg;

  localparam int unsigned KEY_SIZE_DEFAULT  = 16;
  localparam int unsigned KEY_WIDTH_DEFAULT = 4;
  localparam int unsigned CNT_WIDTH_DEFAULT = 5;

  localparam logic [1:0] CORE_0    = 2'd0;
  localparam logic [1:0] CORE_1    = 2'd1;
  localparam logic [1:0] CORE_2    = 2'd2;
  localparam logic [1:0] CORE_NONE = 2'd3;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDecAck = 2'd1;
  localparam logic [1:0] StRstAck = 2'd2;

  // Lowest active core holding fingerprints, or CORE_NONE.
  function automatic logic [1:0] first_core(logic nz0, logic nz1, logic nz2, logic nmr);
    if (nz0)             return CORE_0;
    else if (nz1)        return CORE_1;
    else if (nz2 && nmr) return CORE_2;
    else                 return CORE_NONE;
  endfunction

endpackage

// File: rtl/fprint_oflow_task_cnt.sv
// Per-task fingerprint counters, one per logical core.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   nmr              1 = core 2 participates in ready/remaining/decrement
//   store[2:0]       per-core store strobe for this task
//   dec              decrement all active-core counters
//   clr              clear all counters (wins over a concurrent store)
//   cnt0..cnt2       registered counter values
//   ready            every active core has a fingerprint pending
//   remaining        any active core has a fingerprint pending
//   err              pulse: store on a saturated counter or decrement of zero
module fprint_oflow_task_cnt
  import fprint_oflow_tracker_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 nmr,
  input  logic [2:0]           store,
  input  logic                 dec,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic                 ready,
  output logic                 remaining,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  logic [2:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]                err_c, nz, active;

  assign active = {nmr, 2'b11};

  always_comb begin
    cnt_d = cnt_q;
    err_c = '0;
    for (int c = 0; c < 3; c++) begin
      if (clr) begin
        cnt_d[c] = '0;
      end else if (store[c] && dec && active[c]) begin
        // Store and compare of the same fingerprint slot cancel out.
        cnt_d[c] = cnt_q[c];
      end else if (store[c]) begin
        if (cnt_q[c] == CntMax) err_c[c] = 1'b1;
        else                    cnt_d[c] = cnt_q[c] + 1'b1;
      end else if (dec && active[c]) begin
        if (cnt_q[c] == '0) err_c[c] = 1'b1;
        else                cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  for (genvar c = 0; c < 3; c++) begin : g_nz
    assign nz[c] = |cnt_q[c];
  end

  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign ready     = nz[0] & nz[1] & (nz[2] | ~nmr);
  assign remaining = nz[0] | nz[1] | (nz[2] & nmr);
  assign err       = |err_c;

endmodule

// File: rtl/fprint_oflow_tracker.sv
// Overflow-register responder for the fingerprint comparator.
// Tracks fingerprints stored but not yet compared per (logical core, task), serves the
// comparator's count-decrement and task-reset handshakes, and reports per-task status.
// Ports:
//   clk, reset                               clock, asynchronous active-high reset
//   comparator_nmr                           1 = triple-core mode, 0 = dual-core mode
//   fprint_store/_core_id/_task_id           store strobe with its core and task
//   comparator_task_id                       task the comparator works on
//   comparator_count_dec / oflow_count_dec_ack   decrement request / one-cycle ack
//   oflow_reset_task / oflow_reset_task_ack      clear request / one-cycle ack
//   oflow_fprints_ready/_remaining           per-task status vectors
//   oflow_fprints_remaining_logical_core_id  lowest pending core of comparator_task_id
//   oflow_error                              sticky overflow/underflow flag
// Optional (FPRINT_OFLOW_ERR_ID_EN): oflow_error_clear input, oflow_error_task_id output.
module fprint_oflow_tracker
  import fprint_oflow_tracker_pkg::*;
#(
  parameter int unsigned KEY_SIZE  = KEY_SIZE_DEFAULT,
  parameter int unsigned KEY_WIDTH = KEY_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 comparator_nmr,
  input  logic                 fprint_store,
  input  logic [1:0]           fprint_store_core_id,
  input  logic [KEY_WIDTH-1:0] fprint_store_task_id,
  input  logic [KEY_WIDTH-1:0] comparator_task_id,
  input  logic                 comparator_count_dec,
  output logic                 oflow_count_dec_ack,
  input  logic                 oflow_reset_task,
  output logic                 oflow_reset_task_ack,
  output logic [KEY_SIZE-1:0]  oflow_fprints_ready,
  output logic [KEY_SIZE-1:0]  oflow_fprints_remaining,
  output logic [1:0]           oflow_fprints_remaining_logical_core_id,
  output logic                 oflow_error
`ifdef FPRINT_OFLOW_ERR_ID_EN
  ,
  input  logic                 oflow_error_clear,
  output logic [KEY_WIDTH-1:0] oflow_error_task_id
`endif
);

  logic [1:0]          state_q, state_d;
  logic                dec_fire, clr_fire;
  logic [KEY_SIZE-1:0] err_vec;
  logic                err_any, err_q, err_d;

  logic [CNT_WIDTH-1:0] cnt0 [KEY_SIZE];
  logic [CNT_WIDTH-1:0] cnt1 [KEY_SIZE];
  logic [CNT_WIDTH-1:0] cnt2 [KEY_SIZE];

  // Counter actions happen only on the idle->ack edge, so a request still held during
  // the ack cycle is not serviced twice.
  always_comb begin
    state_d  = state_q;
    dec_fire = 1'b0;
    clr_fire = 1'b0;
    case (state_q)
      StIdle: begin
        if (comparator_count_dec) begin
          dec_fire = 1'b1;
          state_d  = StDecAck;
        end else if (oflow_reset_task) begin
          clr_fire = 1'b1;
          state_d  = StRstAck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  assign oflow_count_dec_ack  = (state_q == StDecAck);
  assign oflow_reset_task_ack = (state_q == StRstAck);

  for (genvar t = 0; t < KEY_SIZE; t++) begin : g_task
    logic       store_hit, cmp_hit;
    logic [2:0] store_vec;

    assign store_hit = fprint_store && (fprint_store_task_id == KEY_WIDTH'(t));
    assign cmp_hit   = (comparator_task_id == KEY_WIDTH'(t));
    // Core id 3 matches no bit and is dropped here.
    assign store_vec = {3{store_hit}} & {fprint_store_core_id == CORE_2,
                                         fprint_store_core_id == CORE_1,
                                         fprint_store_core_id == CORE_0};

    fprint_oflow_task_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_task_cnt (
      .clk       (clk),
      .reset     (reset),
      .nmr       (comparator_nmr),
      .store     (store_vec),
      .dec       (dec_fire && cmp_hit),
      .clr       (clr_fire && cmp_hit),
      .cnt0      (cnt0[t]),
      .cnt1      (cnt1[t]),
      .cnt2      (cnt2[t]),
      .ready     (oflow_fprints_ready[t]),
      .remaining (oflow_fprints_remaining[t]),
      .err       (err_vec[t])
    );
  end

  assign oflow_fprints_remaining_logical_core_id = first_core(
    |cnt0[comparator_task_id], |cnt1[comparator_task_id], |cnt2[comparator_task_id],
    comparator_nmr);

  assign err_any     = |err_vec;
  assign oflow_error = err_q;

`ifdef FPRINT_OFLOW_ERR_ID_EN
  logic [KEY_WIDTH-1:0] err_id_q, err_id_d, err_task;

  // Lowest task raising an error this cycle.
  always_comb begin
    err_task = '0;
    for (int i = KEY_SIZE - 1; i >= 0; i--) begin
      if (err_vec[i]) err_task = KEY_WIDTH'(i);
    end
  end

  // A new error in the clear cycle survives the clear and is captured.
  always_comb begin
    err_d    = err_any | (err_q & ~oflow_error_clear);
    err_id_d = err_id_q;
    if (err_any && (!err_q || oflow_error_clear)) err_id_d = err_task;
    else if (oflow_error_clear)                   err_id_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_id_q <= '0;
    else       err_id_q <= err_id_d;
  end

  assign oflow_error_task_id = err_id_q;
`else
  always_comb err_d = err_q | err_any;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

endmodule

// File: tb/tb_fprint_oflow_tracker.sv
module tb_fprint_oflow_tracker;

  localparam int KS = 16;
  localparam int KW = 4;

  localparam int K_RDY  = 0;
  localparam int K_REM  = 1;
  localparam int K_RDYB = 2;
  localparam int K_REMB = 3;
  localparam int K_CID  = 4;
  localparam int K_ERR  = 5;
  localparam int K_DACK = 6;
  localparam int K_RACK = 7;
  localparam int K_EID  = 8;

  localparam int ACK_DEC = 1;
  localparam int ACK_RST = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          comparator_nmr;
  logic          fprint_store;
  logic [1:0]    fprint_store_core_id;
  logic [KW-1:0] fprint_store_task_id;
  logic [KW-1:0] comparator_task_id;
  logic          comparator_count_dec;
  logic          oflow_count_dec_ack;
  logic          oflow_reset_task;
  logic          oflow_reset_task_ack;
  logic [KS-1:0] oflow_fprints_ready;
  logic [KS-1:0] oflow_fprints_remaining;
  logic [1:0]    oflow_fprints_remaining_logical_core_id;
  logic          oflow_error;
`ifdef FPRINT_OFLOW_ERR_ID_EN
  logic          oflow_error_clear;
  logic [KW-1:0] oflow_error_task_id;
`endif

  fprint_oflow_tracker dut (
    .clk                                     (clk),
    .reset                                   (reset),
    .comparator_nmr                          (comparator_nmr),
    .fprint_store                            (fprint_store),
    .fprint_store_core_id                    (fprint_store_core_id),
    .fprint_store_task_id                    (fprint_store_task_id),
    .comparator_task_id                      (comparator_task_id),
    .comparator_count_dec                    (comparator_count_dec),
    .oflow_count_dec_ack                     (oflow_count_dec_ack),
    .oflow_reset_task                        (oflow_reset_task),
    .oflow_reset_task_ack                    (oflow_reset_task_ack),
    .oflow_fprints_ready                     (oflow_fprints_ready),
    .oflow_fprints_remaining                 (oflow_fprints_remaining),
    .oflow_fprints_remaining_logical_core_id (oflow_fprints_remaining_logical_core_id),
    .oflow_error                             (oflow_error)
`ifdef FPRINT_OFLOW_ERR_ID_EN
    ,
    .oflow_error_clear                       (oflow_error_clear),
    .oflow_error_task_id                     (oflow_error_task_id)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int    kind;
    int    idx;
    int    exp;
    string name;
  } probe_t;

  probe_t chk_q[$];
  int     ack_q[$];
  int     checks   = 0;
  int     failures = 0;

  function automatic int actual(int kind, int idx);
    case (kind)
      K_RDY:   return int'(oflow_fprints_ready);
      K_REM:   return int'(oflow_fprints_remaining);
      K_RDYB:  return int'(oflow_fprints_ready[idx]);
      K_REMB:  return int'(oflow_fprints_remaining[idx]);
      K_CID:   return int'(oflow_fprints_remaining_logical_core_id);
      K_ERR:   return int'(oflow_error);
      K_DACK:  return int'(oflow_count_dec_ack);
      K_RACK:  return int'(oflow_reset_task_ack);
`ifdef FPRINT_OFLOW_ERR_ID_EN
      K_EID:   return int'(oflow_error_task_id);
`endif
      default: return -1;
    endcase
  endfunction

  // Monitor: drains status probes and matches every ack against the expected queue.
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      probe_t p;
      int a;
      p = chk_q.pop_front();
      a = actual(p.kind, p.idx);
      checks++;
      if (a != p.exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d", p.name, a, p.exp);
      end
    end
    if (oflow_count_dec_ack || oflow_reset_task_ack) begin
      int got;
      got = oflow_count_dec_ack ? ACK_DEC : ACK_RST;
      checks++;
      if (oflow_count_dec_ack && oflow_reset_task_ack) begin
        failures++;
        $display("FAIL ack_both: got both acks expected one");
      end else if (ack_q.size() == 0) begin
        failures++;
        $display("FAIL ack_unexpected: got ack kind %0d expected none", got);
      end else begin
        int e;
        e = ack_q.pop_front();
        if (e != got) begin
          failures++;
          $display("FAIL ack_kind: got %0d expected %0d", got, e);
        end
      end
    end
  end

  task automatic probe(int kind, int idx, int exp, string name);
    probe_t p;
    p.kind = kind;
    p.idx  = idx;
    p.exp  = exp;
    p.name = name;
    chk_q.push_back(p);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(int core, int tsk);
    fprint_store         = 1'b1;
    fprint_store_core_id = 2'(core);
    fprint_store_task_id = KW'(tsk);
    cycle();
    fprint_store = 1'b0;
  endtask

  // Full handshake; an optional store rides in the request's first cycle.
  task automatic do_req(int is_dec, int tsk, int st_en, int st_core, int st_task);
    bit got;
    got = 1'b0;
    comparator_task_id = KW'(tsk);
    if (is_dec != 0) comparator_count_dec = 1'b1;
    else             oflow_reset_task     = 1'b1;
    ack_q.push_back(is_dec != 0 ? ACK_DEC : ACK_RST);
    if (st_en != 0) begin
      fprint_store         = 1'b1;
      fprint_store_core_id = 2'(st_core);
      fprint_store_task_id = KW'(st_task);
    end
    for (int i = 0; i < 8; i++) begin
      cycle();
      fprint_store = 1'b0;
      if (oflow_count_dec_ack || oflow_reset_task_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      failures++;
      $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
    end
    probe(is_dec != 0 ? K_DACK : K_RACK, 0, 1, "ack_high");
    cycle();
    comparator_count_dec = 1'b0;
    oflow_reset_task     = 1'b0;
    probe(is_dec != 0 ? K_DACK : K_RACK, 0, 0, "ack_one_cycle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    comparator_nmr       = 1'b1;
    fprint_store         = 1'b0;
    fprint_store_core_id = 2'd0;
    fprint_store_task_id = '0;
    comparator_task_id   = '0;
    comparator_count_dec = 1'b0;
    oflow_reset_task     = 1'b0;
`ifdef FPRINT_OFLOW_ERR_ID_EN
    oflow_error_clear    = 1'b0;
`endif
    repeat (2) cycle();
    reset = 1'b0;

    // Reset state.
    probe(K_RDY, 0, 0, "rst_ready");
    probe(K_REM, 0, 0, "rst_remaining");
    probe(K_CID, 0, 3, "rst_core_id");
    probe(K_ERR, 0, 0, "rst_error");
    probe(K_DACK, 0, 0, "rst_dec_ack");
    probe(K_RACK, 0, 0, "rst_rst_ack");
    cycle();

    // Triple-core fill of task 5.
    comparator_task_id = KW'(5);
    do_store(0, 5);
    probe(K_RDYB, 5, 0, "t5_ready_c0");
    probe(K_REMB, 5, 1, "t5_rem_c0");
    probe(K_CID, 0, 0, "t5_cid_c0");
    do_store(1, 5);
    probe(K_RDYB, 5, 0, "t5_ready_c01");
    do_store(2, 5);
    probe(K_RDY, 0, 16'h0020, "t5_ready_vec");
    probe(K_REM, 0, 16'h0020, "t5_rem_vec");
    probe(K_CID, 0, 0, "t5_cid");

    // Counts 2/2/2, two handshakes: each must decrement exactly once.
    do_store(0, 5);
    do_store(1, 5);
    do_store(2, 5);
    do_req(1, 5, 0, 0, 0);
    probe(K_RDYB, 5, 1, "t5_ready_after_dec1");
    probe(K_ERR, 0, 0, "t5_err_after_dec1");
    do_req(1, 5, 0, 0, 0);
    probe(K_REMB, 5, 0, "t5_rem_after_dec2");
    probe(K_RDYB, 5, 0, "t5_ready_after_dec2");
    probe(K_CID, 0, 3, "t5_cid_after_dec2");
    probe(K_ERR, 0, 0, "t5_err_after_dec2");
    cycle();

    // Dual-core mode, task 3 on core 1 only; core 2 excluded from status.
    comparator_nmr     = 1'b0;
    comparator_task_id = KW'(3);
    do_store(1, 3);
    probe(K_RDYB, 3, 0, "t3_ready");
    probe(K_REMB, 3, 1, "t3_rem");
    probe(K_CID, 0, 1, "t3_cid");
    do_store(2, 7);
    probe(K_REM, 0, 16'h0008, "dmr_core2_excluded");
    cycle();
    comparator_nmr     = 1'b1;
    comparator_task_id = KW'(7);
    probe(K_REM, 0, 16'h0088, "tmr_core2_included");
    probe(K_CID, 0, 2, "t7_cid_core2");
    cycle();
    comparator_nmr = 1'b0;

    // Store to t3 core 0 (count 0) together with the decrement of t3.
    do_req(1, 3, 1, 0, 3);
    probe(K_REM, 0, 0, "store_dec_rem");
    probe(K_CID, 0, 3, "store_dec_cid");
    probe(K_ERR, 0, 0, "store_dec_no_err");
    cycle();

    // Saturate core 2 of task 0.
    comparator_nmr     = 1'b1;
    comparator_task_id = KW'(0);
    for (int i = 0; i < 31; i++) do_store(2, 0);
    probe(K_ERR, 0, 0, "sat_31_no_err");
    probe(K_CID, 0, 2, "sat_cid");
    probe(K_REMB, 0, 1, "sat_rem");
    do_store(2, 0);
    probe(K_ERR, 0, 1, "sat_32_err");
    probe(K_RDY, 0, 0, "sat_ready_vec");
`ifdef FPRINT_OFLOW_ERR_ID_EN
    probe(K_EID, 0, 0, "sat_err_task");
`endif
    cycle();

    // Task 9 counts 4/0/7, then clear with a colliding store.
    comparator_task_id = KW'(9);
    for (int i = 0; i < 4; i++) do_store(0, 9);
    for (int i = 0; i < 7; i++) do_store(2, 9);
    probe(K_RDYB, 9, 0, "t9_ready");
    probe(K_REMB, 9, 1, "t9_rem");
    probe(K_CID, 0, 0, "t9_cid");
    do_req(0, 9, 1, 1, 9);
    probe(K_REMB, 9, 0, "t9_rem_cleared");
    probe(K_CID, 0, 3, "t9_cid_cleared");
    probe(K_REM, 0, 16'h0081, "clr_rem_vec");
    probe(K_ERR, 0, 1, "err_sticky");
    cycle();

    // Asynchronous reset during the ack cycle; the held request is served afterwards.
    comparator_task_id = KW'(2);
    oflow_reset_task   = 1'b1;
    ack_q.push_back(ACK_RST);
    cycle();
    #1;
    reset = 1'b1;
    probe(K_RACK, 0, 0, "async_ack_drop");
    probe(K_ERR, 0, 0, "async_err_clear");
    probe(K_REM, 0, 0, "async_cnt_clear");
    cycle();
    reset = 1'b0;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
        cycle();
        if (oflow_reset_task_ack) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        failures++;
        $display("FAIL post_reset_ack: got no ack expected ack within 8 cycles");
      end
    end
    cycle();
    oflow_reset_task = 1'b0;
    probe(K_RACK, 0, 0, "post_reset_ack_low");
    cycle();

    @(negedge clk);
    #1;
    checks++;
    if (ack_q.size() != 0) begin
      failures++;
      $display("FAIL ack_missing: got %0d outstanding expected 0", ack_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
